// File: rtl/gray_code_counter.sv
// ---------------------------------------------------------------------------
// gray_code_counter
//
// Purpose:
//   Binary up/down counter that emits the Gray encoding of each count value
//   as a registered beat under a valid/ready handshake. Each beat also
//   carries the binary value it was derived from, so a downstream
//   Gray-to-binary converter can be checked beat-for-beat. A parallel load
//   repositions the count. A wrap flag marks the last beat before the count
//   rolls over in the current direction.
//
// Parameters:
//   WIDTH      count, Gray and binary width (>= 2)
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   en         in   1      request to emit current count and advance
//   up_dn      in   1      1 = count up, 0 = count down (used on step)
//   load       in   1      parallel load of count, priority over en
//   load_val   in   WIDTH  binary value loaded when load = 1
//   out_valid  out  1      gray_out/bin_out/wrap hold a beat
//   out_ready  in   1      downstream accepts when out_valid & out_ready
//   gray_out   out  WIDTH  Gray code of emitted count
//   bin_out    out  WIDTH  binary value of emitted count
//   wrap       out  1      beat is the last before the count wraps
// ---------------------------------------------------------------------------
module gray_code_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Binary to reflected Gray code: each bit is the XOR of itself and the
  // next more significant bit.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    bin2gray = b ^ (b >> 1);
  endfunction

  // State registers
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] gray_r;
  logic [WIDTH-1:0] bin_r;
  logic             wrap_r;
  logic             valid_r;

  // Next-state values
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] bin_s;
  logic             wrap_s;
  logic             valid_s;

  // Handshake qualifiers
  logic             accept_s;
  logic             slot_free_s;
  logic             step_s;

  // Handshake decode: the output slot may be refilled when it is empty or
  // when the current beat is being taken this cycle.
  always_comb begin
    accept_s    = valid_r & out_ready;
    slot_free_s = ~valid_r | out_ready;
    step_s      = en & slot_free_s & ~load;
  end

  // Next-state selection in priority order load > step > drain > hold.
  always_comb begin
    cnt_s   = cnt_r;
    gray_s  = gray_r;
    bin_s   = bin_r;
    wrap_s  = wrap_r;
    valid_s = valid_r;
    if (load) begin
      // A pending beat is flushed even if it is accepted this same cycle.
      cnt_s   = load_val;
      wrap_s  = 1'b0;
      valid_s = 1'b0;
    end else if (step_s) begin
      // The emitted beat is always the current count; up_dn only picks the
      // increment applied afterwards.
      gray_s  = bin2gray(cnt_r);
      bin_s   = cnt_r;
      valid_s = 1'b1;
      if (up_dn) begin
        wrap_s = (cnt_r == ALL_ONES);
        cnt_s  = cnt_r + ONE;
      end else begin
        wrap_s = (cnt_r == ALL_ZERO);
        cnt_s  = cnt_r - ONE;
      end
    end else if (accept_s) begin
      // Drain: data registers keep their last values, only valid drops.
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // State update with synchronous active-low reset; reset discards any beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= ALL_ZERO;
      gray_r  <= ALL_ZERO;
      bin_r   <= ALL_ZERO;
      wrap_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      gray_r  <= gray_s;
      bin_r   <= bin_s;
      wrap_r  <= wrap_s;
      valid_r <= valid_s;
    end
  end

  assign out_valid = valid_r;
  assign gray_out  = gray_r;
  assign bin_out   = bin_r;
  assign wrap      = wrap_r;

endmodule

// File: tb/tb_gray_code_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_code_counter
//
// Directed self-checking bench for gray_code_counter (WIDTH = 8). Inputs are
// driven and outputs sampled on the falling edge; the DUT updates on the
// rising edge.
// ---------------------------------------------------------------------------
module tb_gray_code_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] gray_out;
  logic [7:0] bin_out;
  logic       wrap;

  int vec_cnt;
  int err_cnt;

  gray_code_counter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .wrap      (wrap)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vec_cnt = vec_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check one full beat.
  task automatic check_beat(input string tag, input logic [7:0] g,
                            input logic [7:0] b, input logic w);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".gray"},  32'(gray_out),  32'(g));
    check({tag, ".bin"},   32'(bin_out),   32'(b));
    check({tag, ".wrap"},  32'(wrap),      32'(w));
  endtask

  // Reference Gray-to-binary conversion as done by the downstream block.
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  function automatic int popcount8(input logic [7:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) n = n + int'(v[k]);
    return n;
  endfunction

  logic [7:0] gray_tbl [8];
  logic [7:0] prev_gray;
  logic [7:0] exp_bin;
  int         acc_cnt;
  int         cyc;

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    up_dn     = 1'b1;
    load      = 1'b0;
    load_val  = 8'h00;
    out_ready = 1'b1;
    gray_tbl  = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};

    // Reset state
    @(negedge clk);
    tick();
    tick();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.gray",  32'(gray_out),  32'd0);
    check("rst.bin",   32'(bin_out),   32'd0);
    check("rst.wrap",  32'(wrap),      32'd0);

    // Up-stream of 8 beats from 0
    rst_n = 1'b1;
    en    = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_beat($sformatf("up%0d", i), gray_tbl[i], 8'(i), 1'b0);
    end

    // Back-pressure: beat 7 frozen for 5 cycles, then successors 8 and 9
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_beat($sformatf("hold%0d", i), 8'h04, 8'h07, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check_beat("rel0", 8'h0C, 8'h08, 1'b0);
    tick();
    check_beat("rel1", 8'h0D, 8'h09, 1'b0);

    // Load FE, then up through the wrap
    load     = 1'b1;
    load_val = 8'hFE;
    tick();
    check("load.valid", 32'(out_valid), 32'd0);
    check("load.wrap",  32'(wrap),      32'd0);
    load = 1'b0;
    tick();
    check_beat("ld0", 8'h81, 8'hFE, 1'b0);
    tick();
    check_beat("ld1", 8'h80, 8'hFF, 1'b1);
    tick();
    check_beat("ld2", 8'h00, 8'h00, 1'b0);

    // Reset then count down
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    up_dn = 1'b0;
    tick();
    check_beat("dn0", 8'h00, 8'h00, 1'b1);
    tick();
    check_beat("dn1", 8'h80, 8'hFF, 1'b0);

    // Reset while a beat is stalled
    up_dn     = 1'b1;
    out_ready = 1'b0;
    tick();
    check("stall.valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mrst.valid", 32'(out_valid), 32'd0);
    check("mrst.gray",  32'(gray_out),  32'd0);
    check("mrst.bin",   32'(bin_out),   32'd0);
    check("mrst.wrap",  32'(wrap),      32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_beat("mrst.first", 8'h00, 8'h00, 1'b0);

    // Full 256-beat up-stream with random back-pressure
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    en        = 1'b1;
    up_dn     = 1'b1;
    exp_bin   = 8'h00;
    prev_gray = 8'h00;
    acc_cnt   = 0;
    cyc       = 0;
    while (acc_cnt < 256 && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        check("s.conv", 32'(gray2bin(gray_out)), 32'(bin_out));
        check("s.bin",  32'(bin_out), 32'(exp_bin));
        check("s.wrap", 32'(wrap), 32'(exp_bin == 8'hFF));
        if (acc_cnt > 0) begin
          check("s.onebit", 32'(popcount8(gray_out ^ prev_gray)), 32'd1);
        end else begin
          check("s.first", 32'(gray_out), 32'd0);
        end
        prev_gray = gray_out;
        exp_bin   = exp_bin + 8'd1;
        acc_cnt   = acc_cnt + 1;
      end
      tick();
      cyc = cyc + 1;
    end
    check("s.count", 32'(acc_cnt), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gray_code_counter.md
# gray_code_counter

Sequential Gray-code source that sits directly upstream of the Gray-to-binary converter. It holds a binary count and emits the Gray encoding of each count value as a registered output beat under a valid/ready handshake. It supports up/down stepping and parallel load, and flags the wrap beat. Every beat also carries the registered binary value, so the converter's output can be checked against it beat-for-beat.

## Interface
- WIDTH, 8: count, Gray and binary width (≥2).

- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- en  in  1  request to emit the current count and advance.
- up_dn  in  1  1 = count up, 0 = count down; sampled only on a step cycle.
- load  in  1  parallel load of count; priority over en.
- load_val  in  WIDTH  binary value loaded when load=1.
- out_valid  out  1  gray_out/bin_out/wrap hold a beat.
- out_ready  in  1  downstream accepts beat when out_valid & out_ready.
- gray_out  out  WIDTH  Gray code of emitted count: b ^ (b >> 1).
- bin_out  out  WIDTH  binary value of emitted count (reference for downstream check).
- wrap  out  1  beat is the last before wrap: bin_out = all-ones when counting up, 0 when counting down.

## Operation
- Internal register cnt (WIDTH bits, binary). Output register holds gray_out, bin_out, wrap, out_valid.
- Definitions:
  - accept = out_valid & out_ready.
  - slot_free = !out_valid | out_ready.
  - step = en & slot_free & !load.
- Priority per cycle: reset > load > step > drain.
- Reset (rst_n=0 at edge): cnt=0, gray_out=0, bin_out=0, wrap=0, out_valid=0. Applies mid-stream; any pending beat is discarded.
- Load (load=1): cnt ← load_val, out_valid ← 0, wrap ← 0. A pending beat is flushed, even if accepted in the same cycle. en is ignored that cycle.
- Step:
  - gray_out ← cnt ^ (cnt >> 1), bin_out ← cnt, out_valid ← 1.
  - wrap ← (up_dn & cnt = all-ones) | (!up_dn & cnt = 0).
  - cnt ← cnt + 1 if up_dn, else cnt − 1, modulo 2^WIDTH (natural wrap, no saturation).
- Drain (no load, no step, accept): out_valid ← 0. gray_out, bin_out and wrap hold their last values.
- Hold (out_valid=1, out_ready=0): all output registers and cnt stable; en has no effect.
- Direction change: the next emitted beat is still the current cnt. up_dn only sets the increment applied after that emit.
- Consecutive accepted beats without an intervening load differ in exactly one gray_out bit.

## Timing
- Registered outputs only; no combinational path from any input to any output.
- Step at edge N → beat visible after edge N, acceptable at edge N+1.
- Throughput: one beat per cycle with en=1 and out_ready=1. Accept and the next step may occur at the same edge.
- First beat after reset or load appears 1 cycle after the first step cycle. It carries the reset value (0) or load_val.
- load → out_valid=0 after that edge. The earliest new beat is at the following edge if en=1.

## Test plan
- Reset, then en=1, up_dn=1, out_ready=1 for 8 cycles → gray_out sequence 00,01,03,02,06,07,05,04; bin_out 0..7; wrap=0 throughout.
- Mid-stream, out_ready=0 for 5 cycles with en=1 → gray_out, bin_out and out_valid frozen. On release, the next beat is the immediate successor, with no skip or duplicate.
- load=1, load_val=8'hFE, then up-stream → beats gray 81 (bin FE, wrap=0), 80 (bin FF, wrap=1), 00 (bin 00, wrap=0).
- After reset, up_dn=0, stream 2 beats → gray 00 (bin 00, wrap=1), then 80 (bin FF, wrap=0).
- Reset asserted with out_valid=1 and out_ready=0 → out_valid=0 and all outputs 0 after the edge; the next step emits gray 00.
- Full 256-beat up-stream with random out_ready → each beat converted by the downstream Gray-to-binary block equals bin_out. Successive gray_out beats differ in exactly one bit. wrap occurs only on bin FF.
